// File: rtl/router_pkg.sv
// Shared constants and types for the router read-side output port.
// The FIFO word carries the load-first-data flag above the data byte.
package router_pkg;

   localparam int DATA_W = 8;
   localparam int DEPTH  = 16;
   localparam int LEN_W  = 6;
   localparam int ADDR_W = $clog2(DEPTH);
   localparam int PTR_W  = ADDR_W + 1;
   localparam int CNT_W  = LEN_W + 1;

   typedef logic [DATA_W:0] fifo_word_t;

endpackage

// File: rtl/router_rd_fifo_mem.sv
// Register-array storage for the read port FIFO.
// One synchronous write port and one combinational read port.
module router_rd_fifo_mem
   import router_pkg::*;
(
   input  logic              clock,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  fifo_word_t        wdata,
   input  logic [ADDR_W-1:0] raddr,
   output fifo_word_t        rdata
);

   fifo_word_t mem [DEPTH];

   // NOTE: storage is left unreset; the pointers alone decide which entries are meaningful.
   always_ff @(posedge clock) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/router_rd_port.sv
// Read-side output port of the 1x3 router: buffers bytes from the core,
// hands them to the destination on request and tracks packet boundaries.
module router_rd_port
   import router_pkg::*;
(
   input  logic              clock,
   input  logic              resetn,
   input  logic              soft_reset,
   input  logic              write_enb,
   input  logic              lfd_state,
   input  logic [DATA_W-1:0] data_in,
   input  logic              read_enb,
   output logic [DATA_W-1:0] data_out,
   output logic              vld_out,
   output logic              full,
   output logic              empty
);

   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  count;
   logic [CNT_W-1:0]  count_nxt;
   logic              idle_pending;
   logic              idle_nxt;
   logic [DATA_W-1:0] data_nxt;
   logic              do_wr;
   logic              do_rd;
   fifo_word_t        rd_word;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                    (wr_ptr[PTR_W-2:0] == rd_ptr[PTR_W-2:0]);
   assign vld_out = !empty;

   assign do_wr = write_enb && !full && !soft_reset;
   assign do_rd = read_enb && !empty;

   router_rd_fifo_mem u_mem (
      .clock (clock),
      .we    (do_wr),
      .waddr (wr_ptr[PTR_W-2:0]),
      .wdata ({lfd_state, data_in}),
      .raddr (rd_ptr[PTR_W-2:0]),
      .rdata (rd_word)
   );

   // A header pop reloads the count with payload length plus parity; once the
   // last byte has gone, the bus is zeroed on the first cycle without a pop.
   always_comb begin
      // NOTE: every output of this block is defaulted first so no path can infer a latch.
      count_nxt = count;
      idle_nxt  = idle_pending;
      data_nxt  = data_out;
      if (do_rd) begin
         data_nxt = rd_word[DATA_W-1:0];
         if (rd_word[DATA_W]) begin
            count_nxt = {1'b0, rd_word[DATA_W-1 -: LEN_W]} + CNT_W'(1);
            idle_nxt  = 1'b0;
         end else begin
            if (count != '0) begin
               count_nxt = count - CNT_W'(1);
            end
            idle_nxt = (count <= CNT_W'(1));
         end
      end else if (idle_pending) begin
         data_nxt = '0;
         idle_nxt = 1'b0;
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         idle_pending <= 1'b0;
         data_out     <= '0;
      end else if (soft_reset) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         idle_pending <= 1'b0;
         data_out     <= '0;
      end else begin
         // NOTE: non-blocking updates so every register samples pre-edge values.
         if (do_wr) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (do_rd) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         count        <= count_nxt;
         idle_pending <= idle_nxt;
         data_out     <= data_nxt;
      end
   end

endmodule

// File: tb/tb_router_rd_port.sv
// Directed self-checking bench for router_rd_port.
// Inputs change on the falling edge; outputs are sampled on the next falling edge.
module tb_router_rd_port;
   import router_pkg::*;

   logic              clock;
   logic              resetn;
   logic              soft_reset;
   logic              write_enb;
   logic              lfd_state;
   logic [DATA_W-1:0] data_in;
   logic              read_enb;
   logic [DATA_W-1:0] data_out;
   logic              vld_out;
   logic              full;
   logic              empty;

   int checks   = 0;
   int failures = 0;

   logic [7:0] pkt [5] = '{8'h0D, 8'hA1, 8'hA2, 8'hA3, 8'h5F};

   router_rd_port dut (
      .clock      (clock),
      .resetn     (resetn),
      .soft_reset (soft_reset),
      .write_enb  (write_enb),
      .lfd_state  (lfd_state),
      .data_in    (data_in),
      .read_enb   (read_enb),
      .data_out   (data_out),
      .vld_out    (vld_out),
      .full       (full),
      .empty      (empty)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic we, input logic lfd, input logic [7:0] din, input logic re);
      write_enb = we;
      lfd_state = lfd;
      data_in   = din;
      read_enb  = re;
      @(negedge clock);
   endtask

   initial begin
      resetn     = 1'b0;
      soft_reset = 1'b0;
      write_enb  = 1'b0;
      lfd_state  = 1'b0;
      data_in    = '0;
      read_enb   = 1'b0;

      // Reset
      repeat (2) @(negedge clock);
      check("rst_hold_empty", 32'(empty), 32'd1);
      resetn = 1'b1;
      @(negedge clock);
      check("rst_empty", 32'(empty), 32'd1);
      check("rst_vld", 32'(vld_out), 32'd0);
      check("rst_full", 32'(full), 32'd0);
      check("rst_data", 32'(data_out), 32'h00);

      // Single packet: header 0D carries length 3, so count = 4
      step(1'b1, 1'b1, pkt[0], 1'b0);
      check("pkt_vld_first", 32'(vld_out), 32'd1);
      for (int i = 1; i < 5; i++) step(1'b1, 1'b0, pkt[i], 1'b0);
      check("pkt_data_before_read", 32'(data_out), 32'h00);
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 1'b0, 8'h00, 1'b1);
         check($sformatf("pkt_rd%0d", i), 32'(data_out), 32'(pkt[i]));
      end
      check("pkt_vld_drained", 32'(vld_out), 32'd0);
      check("pkt_empty_drained", 32'(empty), 32'd1);
      step(1'b0, 1'b0, 8'h00, 1'b1);
      check("pkt_idle_zero", 32'(data_out), 32'h00);

      // Full: 16 writes, then a dropped 17th
      for (int i = 0; i < 16; i++) begin
         check($sformatf("full_pre%0d", i), 32'(full), 32'd0);
         step(1'b1, 1'b0, 8'(i), 1'b0);
      end
      check("full_set", 32'(full), 32'd1);
      step(1'b1, 1'b0, 8'hFF, 1'b0);
      check("full_after_drop", 32'(full), 32'd1);
      for (int i = 0; i < 16; i++) begin
         step(1'b0, 1'b0, 8'h00, 1'b1);
         check($sformatf("full_rd%0d", i), 32'(data_out), 32'(i));
      end
      check("full_drained_empty", 32'(empty), 32'd1);
      step(1'b0, 1'b0, 8'h00, 1'b0);
      check("full_idle_zero", 32'(data_out), 32'h00);

      // Simultaneous read/write at occupancy 8 across the pointer wrap
      for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'h20 + 8'(i), 1'b0);
      for (int i = 0; i < 20; i++) begin
         step(1'b1, 1'b0, 8'h28 + 8'(i), 1'b1);
         check($sformatf("sim_rd%0d", i), 32'(data_out), 32'h20 + 32'(i));
         check($sformatf("sim_full%0d", i), 32'(full), 32'd0);
         check($sformatf("sim_empty%0d", i), 32'(empty), 32'd0);
      end
      for (int i = 0; i < 8; i++) begin
         step(1'b0, 1'b0, 8'h00, 1'b1);
         check($sformatf("sim_drain%0d", i), 32'(data_out), 32'h34 + 32'(i));
      end
      check("sim_drained_empty", 32'(empty), 32'd1);
      step(1'b0, 1'b0, 8'h00, 1'b0);

      // Header 41 (length 16) keeps the count non-zero, so data_out holds on empty reads
      step(1'b1, 1'b1, 8'h41, 1'b0);
      step(1'b0, 1'b0, 8'h00, 1'b1);
      check("hold_hdr", 32'(data_out), 32'h41);
      step(1'b0, 1'b0, 8'h00, 1'b1);
      check("hold_empty_rd1", 32'(data_out), 32'h41);
      step(1'b0, 1'b0, 8'h00, 1'b1);
      check("hold_empty_rd2", 32'(data_out), 32'h41);

      // Soft reset with 5 stored entries and a concurrent write
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'h50 + 8'(i), 1'b0);
      check("sr_pre_vld", 32'(vld_out), 32'd1);
      soft_reset = 1'b1;
      step(1'b1, 1'b0, 8'h77, 1'b0);
      soft_reset = 1'b0;
      check("sr_empty", 32'(empty), 32'd1);
      check("sr_vld", 32'(vld_out), 32'd0);
      check("sr_full", 32'(full), 32'd0);
      check("sr_data", 32'(data_out), 32'h00);
      step(1'b0, 1'b0, 8'h00, 1'b1);
      check("sr_write_discarded", 32'(empty), 32'd1);
      check("sr_data_hold", 32'(data_out), 32'h00);
      step(1'b1, 1'b0, 8'h99, 1'b0);
      step(1'b0, 1'b0, 8'h00, 1'b1);
      check("sr_after_rd", 32'(data_out), 32'h99);
      check("sr_after_empty", 32'(empty), 32'd1);
      step(1'b0, 1'b0, 8'h00, 1'b0);

      // Asynchronous reset in the middle of a read burst
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'hC1 + 8'(i), 1'b0);
      step(1'b0, 1'b0, 8'h00, 1'b1);
      check("ar_rd0", 32'(data_out), 32'hC1);
      @(posedge clock);
      #1;
      check("ar_rd1", 32'(data_out), 32'hC2);
      #1;
      resetn = 1'b0;
      #1;
      check("ar_data", 32'(data_out), 32'h00);
      check("ar_empty", 32'(empty), 32'd1);
      check("ar_vld", 32'(vld_out), 32'd0);
      check("ar_full", 32'(full), 32'd0);
      read_enb = 1'b0;
      @(negedge clock);
      resetn = 1'b1;
      step(1'b0, 1'b0, 8'h00, 1'b1);
      check("ar_post_empty", 32'(empty), 32'd1);
      check("ar_post_data", 32'(data_out), 32'h00);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
